// File: rtl/object_centroid_if.sv
// Pixel stream in, object centre out, for the centroid block.
// The upstream detection stage is the master; the centroid block is the slave.
interface object_centroid_if #(
    parameter int DISP_WIDTH = 11
) ();
    logic                  enable;
    logic                  is_obj;
    logic [DISP_WIDTH-1:0] x_pos;
    logic [DISP_WIDTH-1:0] y_pos;
    logic                  frame_end;

    logic [DISP_WIDTH-1:0] x_obj;
    logic [DISP_WIDTH-1:0] y_obj;
    logic                  valid;
    logic                  obj_lost;
    logic                  busy;
    logic                  dropped;

    modport master (
        output enable, is_obj, x_pos, y_pos, frame_end,
        input  x_obj, y_obj, valid, obj_lost, busy, dropped
    );

    modport slave (
        input  enable, is_obj, x_pos, y_pos, frame_end,
        output x_obj, y_obj, valid, obj_lost, busy, dropped
    );
endinterface

// File: rtl/object_centroid.sv
// Object centroid: accumulates the coordinates of every object pixel in a
// frame, then divides both sums by the pixel count in two restoring dividers
// that share the count as divisor. One quotient bit per cycle, MSB first.
//
// state  | meaning
// ACCUM  | idle; waiting for frame_end to close a frame
// DIVIDE | DISP_WIDTH restoring-division iterations in progress
// UPDATE | quotients loaded into x_obj/y_obj, valid pulsed
module object_centroid #(
    parameter int DISP_WIDTH = 11
) (
    input  logic             clk,
    input  logic             areset,
    object_centroid_if.slave bus
);
    localparam int CNT_WIDTH  = 2 * DISP_WIDTH;
    localparam int SUM_WIDTH  = 3 * DISP_WIDTH;
    localparam int ITER_WIDTH = $clog2(DISP_WIDTH + 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Frame accumulators and their values including the current pixel.
    logic                  pix_hit;
    logic [SUM_WIDTH-1:0]  sum_x;
    logic [SUM_WIDTH-1:0]  sum_y;
    logic [CNT_WIDTH-1:0]  count;
    logic [SUM_WIDTH-1:0]  sum_x_close;
    logic [SUM_WIDTH-1:0]  sum_y_close;
    logic [CNT_WIDTH-1:0]  count_close;

    // Divider state. quo_* starts out holding the low DISP_WIDTH dividend
    // bits; each iteration shifts one dividend bit out of the top and one
    // quotient bit in at the bottom, so after DISP_WIDTH steps it holds the
    // quotient. rem_* starts as the upper dividend bits, which are already
    // smaller than the divisor because the quotient fits in DISP_WIDTH bits.
    logic [CNT_WIDTH-1:0]  divisor;
    logic [CNT_WIDTH-1:0]  rem_x;
    logic [CNT_WIDTH-1:0]  rem_y;
    logic [DISP_WIDTH-1:0] quo_x;
    logic [DISP_WIDTH-1:0] quo_y;
    logic [ITER_WIDTH-1:0] iter_cnt;

    logic [CNT_WIDTH:0]    trial_x;
    logic [CNT_WIDTH:0]    trial_y;
    logic                  fit_x;
    logic                  fit_y;
    logic [CNT_WIDTH-1:0]  rem_x_nxt;
    logic [CNT_WIDTH-1:0]  rem_y_nxt;

    // FSM control strobes.
    logic                  load_div;
    logic                  do_iter;
    logic                  do_update;
    logic                  lost_evt;
    logic                  drop_evt;

    // Registered outputs.
    logic [DISP_WIDTH-1:0] x_obj_q;
    logic [DISP_WIDTH-1:0] y_obj_q;
    logic                  valid_q;
    logic                  obj_lost_q;
    logic                  dropped_q;

    assign pix_hit     = bus.enable & bus.is_obj;
    assign sum_x_close = sum_x + (pix_hit ? SUM_WIDTH'(bus.x_pos) : '0);
    assign sum_y_close = sum_y + (pix_hit ? SUM_WIDTH'(bus.y_pos) : '0);
    assign count_close = count + CNT_WIDTH'(pix_hit);

    assign trial_x   = {rem_x, quo_x[DISP_WIDTH-1]};
    assign trial_y   = {rem_y, quo_y[DISP_WIDTH-1]};
    assign fit_x     = (trial_x >= {1'b0, divisor});
    assign fit_y     = (trial_y >= {1'b0, divisor});
    assign rem_x_nxt = fit_x ? CNT_WIDTH'(trial_x - {1'b0, divisor}) : trial_x[CNT_WIDTH-1:0];
    assign rem_y_nxt = fit_y ? CNT_WIDTH'(trial_y - {1'b0, divisor}) : trial_y[CNT_WIDTH-1:0];

    // Accumulate flagged pixels every cycle; frame_end clears after closing.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (bus.frame_end) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else begin
            sum_x <= sum_x_close;
            sum_y <= sum_y_close;
            count <= count_close;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes; a frame_end outside ACCUM is dropped.
    always_comb begin
        state_nxt = state;
        load_div  = 1'b0;
        do_iter   = 1'b0;
        do_update = 1'b0;
        lost_evt  = 1'b0;
        drop_evt  = 1'b0;
        case (state)
            ACCUM: begin
                if (bus.frame_end) begin
                    if (count_close == '0) begin
                        lost_evt = 1'b1;
                    end else begin
                        load_div  = 1'b1;
                        state_nxt = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                do_iter  = 1'b1;
                drop_evt = bus.frame_end;
                if (iter_cnt == ITER_WIDTH'(1)) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                do_update = 1'b1;
                drop_evt  = bus.frame_end;
                state_nxt = ACCUM;
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    // Divider: snapshot the closing frame, then one restoring step per cycle.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            divisor  <= '0;
            rem_x    <= '0;
            rem_y    <= '0;
            quo_x    <= '0;
            quo_y    <= '0;
            iter_cnt <= '0;
        end else if (load_div) begin
            divisor  <= count_close;
            rem_x    <= sum_x_close[SUM_WIDTH-1:DISP_WIDTH];
            rem_y    <= sum_y_close[SUM_WIDTH-1:DISP_WIDTH];
            quo_x    <= sum_x_close[DISP_WIDTH-1:0];
            quo_y    <= sum_y_close[DISP_WIDTH-1:0];
            iter_cnt <= ITER_WIDTH'(DISP_WIDTH);
        end else if (do_iter) begin
            rem_x    <= rem_x_nxt;
            rem_y    <= rem_y_nxt;
            quo_x    <= {quo_x[DISP_WIDTH-2:0], fit_x};
            quo_y    <= {quo_y[DISP_WIDTH-2:0], fit_y};
            iter_cnt <= iter_cnt - ITER_WIDTH'(1);
        end
    end

    // Output registers: centre held between updates, single-cycle pulses.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            x_obj_q    <= '0;
            y_obj_q    <= '0;
            valid_q    <= 1'b0;
            obj_lost_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            valid_q    <= do_update;
            obj_lost_q <= lost_evt;
            dropped_q  <= drop_evt;
            if (do_update) begin
                x_obj_q <= quo_x;
                y_obj_q <= quo_y;
            end
        end
    end

    assign bus.x_obj    = x_obj_q;
    assign bus.y_obj    = y_obj_q;
    assign bus.valid    = valid_q;
    assign bus.obj_lost = obj_lost_q;
    assign bus.dropped  = dropped_q;
    assign bus.busy     = (state == DIVIDE);
endmodule
